pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives PC enable, IF/ID enable and the synchronous `clr` inputs of the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Tracks the multi-cycle mult/div unit with a busy counter and holds D-stage HI/LO users until the result is ready.
- Sequences a one-cycle flush when M raises an exception or eret.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 2..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 2..15).
- CNT_W, 4, width of the busy counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- md_start_e  in  1  E stage holds mult/multu/div/divu.
- md_is_div_e  in  1  qualifies md_start_e: 1 = div class.
- md_use_d  in  1  D stage holds mult/div/mfhi/mflo/mthi/mtlo.
- loaduse_d  in  1  load-use hazard detected by the decode comparator.
- exc_req_m  in  1  exception or interrupt taken at M.
- eret_m  in  1  eret at M.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- idex_clr  out  1  ID/EX clear (bubble insert).
- exmem_clr  out  1  EX/MEM clear.
- memwb_clr  out  1  MEM/WB clear.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  final busy cycle; HI/LO are written at the end of this cycle.

Behaviour:
- States: IDLE, MD_BUSY, FLUSH. Registered state plus CNT_W-bit down-counter `cnt`.
- Reset (asynchronous):
  - state = IDLE, cnt = 0.
  - Outputs: md_busy = 0, md_done = 0, pc_en = 1, ifid_en = 1, all clr = 0.
- Definitions:
  - start_ok = md_start_e & ~exc_req_m & ~eret_m. An E instruction being flushed never starts the unit.
  - flush = exc_req_m | eret_m.
  - stall = ~flush & (loaduse_d | (md_use_d & (md_busy | start_ok))).
- State transitions:
  - IDLE, on start_ok: cnt <= (md_is_div_e ? DIV_CYCLES : MULT_CYCLES) - 1; go to MD_BUSY. md_busy rises the cycle after start.
  - MD_BUSY: cnt decrements each cycle. md_done = 1 when cnt == 0; next state IDLE.
  - Result: md_busy is high for exactly N consecutive cycles.
  - MD_BUSY is not aborted by flush; the in-flight operation completes.
  - FLUSH is entered from any state when flush = 1 and lasts one cycle. MD counting continues in parallel; MD context is kept in a separate busy flag, not lost.
- Outputs are combinational from the current inputs and registered state:
  - flush = 1: pc_en = 1 (handler or EPC load), ifid_en = 1, idex_clr = 1, exmem_clr = 1, memwb_clr = 0.
  - stall = 1: pc_en = 0, ifid_en = 0, idex_clr = 1, exmem_clr = 0.
  - Otherwise: pc_en = 1, ifid_en = 1, all clr = 0.
- Priority: flush > stall. loaduse and md stalls OR together.
- Boundaries:
  - md_start_e while md_busy = 1 is illegal. It is ignored and flagged by a simulation assertion.
  - md_use_d in the cycle md_done = 1 still stalls; the instruction is released the next cycle.
  - md_start_e together with md_use_d (back-to-back mult then mflo) stalls D in the same cycle.
  - Reset asserted mid-busy returns to IDLE immediately.
- Counter never wraps: it is loaded only from IDLE.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- When defined, adds three 32-bit saturating counters plus output ports stat_stall_cyc, stat_md_stall_cyc and stat_flush_cnt (each 32 bits, out):
  - stat_stall_cyc counts cycles with stall.
  - stat_md_stall_cyc counts stall cycles caused by md_use_d.
  - stat_flush_cnt counts flush events.
- All three counters clear on reset and hold at 0xFFFFFFFF.
- When undefined, neither the ports nor the logic exist, and all other behaviour is identical.

Decomposition:
- Shared package `pipe_pkg`:
  - state encoding (IDLE = 2'd0, MD_BUSY = 2'd1, FLUSH = 2'd2).
  - default MULT_CYCLES/DIV_CYCLES constants.
  - CNT_W.
- One sub-module, `md_busy_cnt`: loadable down-counter producing md_busy and md_done from start/len inputs.

Test Plan:
- Reset: assert reset with no clk edge -> outputs equal reset values immediately; hold reset 3 cycles, release -> still idle values.
- Mult: md_start_e = 1, md_is_div_e = 0 at cycle 0 -> md_busy high cycles 1–5, md_done high only cycle 5; md_use_d held high from cycle 0 -> pc_en = 0 cycles 0–5, 1 at cycle 6.
- Div: md_start_e with md_is_div_e = 1 -> md_busy high exactly 10 cycles; no stall when md_use_d = 0.
- Load-use: loaduse_d = 1 for 1 cycle -> pc_en = 0, ifid_en = 0, idex_clr = 1 that cycle only.
- Flush precedence: exc_req_m = 1 with loaduse_d = 1 and md_start_e = 1 -> pc_en = 1, idex_clr = 1, exmem_clr = 1, md_busy stays 0 next cycle; a separate flush during MD_BUSY -> md_done still arrives on schedule.
- Illegal start: md_start_e during busy -> counter unaffected, assertion fires.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default timing for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/md_busy_cnt.sv
// rtl/md_busy_cnt.sv - loadable down-counter tracking mult/div occupancy
module md_busy_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done
);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    // Load len-1 on an accepted start, then count down to zero; busy spans len cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= i_len;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional stats: PIPE_HAZARD_STATS_EN)
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start_e,
    input  logic        md_is_div_e,
    input  logic        md_use_d,
    input  logic        loaduse_d,
    input  logic        exc_req_m,
    input  logic        eret_m,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        memwb_clr,
    output logic        md_busy,
    output logic        md_done
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [31:0] stat_stall_cyc,
    output logic [31:0] stat_md_stall_cyc,
    output logic [31:0] stat_flush_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_flush;
    logic             w_start_ok;
    logic             w_start;
    logic             w_md_stall;
    logic             w_stall;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_len;

    // A flushed E-stage instruction must never launch the unit
    assign w_flush    = exc_req_m | eret_m;
    assign w_start_ok = md_start_e & ~exc_req_m & ~eret_m;
    // Starts while occupied are dropped so the in-flight count is never disturbed
    assign w_start    = w_start_ok & ~w_busy;
    assign w_len      = md_is_div_e ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    // A HI/LO user in D waits while the unit is occupied or being launched this cycle
    assign w_md_stall = ~w_flush & md_use_d & (w_busy | w_start_ok);
    assign w_stall    = (~w_flush & loaduse_d) | w_md_stall;

    md_busy_cnt #(
        .CNT_W (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_len   (w_len),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    assign md_busy = w_busy;
    assign md_done = w_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pipeline control; flush outranks every stall source
    always_comb begin
        w_state_nxt = r_state;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_clr    = 1'b0;
        exmem_clr   = 1'b0;
        memwb_clr   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Return to wherever the parallel busy flag says the unit is
                if ((w_busy & ~w_done) | w_start) begin
                    w_state_nxt = ST_MD_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_flush) begin
            w_state_nxt = ST_FLUSH;
        end

        if (w_flush) begin
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end else if (w_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    // Flag a start that arrives while the unit is still occupied
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(md_start_e && w_busy))
            else $warning("md_start_e while md_busy: start ignored");
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_md_stall;
    logic [31:0] r_stat_flush;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_stall    <= '0;
            r_stat_md_stall <= '0;
            r_stat_flush    <= '0;
        end else begin
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
            if (w_md_stall && (r_stat_md_stall != '1)) begin
                r_stat_md_stall <= r_stat_md_stall + 32'd1;
            end
            if (w_flush && (r_stat_flush != '1)) begin
                r_stat_flush <= r_stat_flush + 32'd1;
            end
        end
    end

    assign stat_stall_cyc    = r_stat_stall;
    assign stat_md_stall_cyc = r_stat_md_stall;
    assign stat_flush_cnt    = r_stat_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    logic md_start_e, md_is_div_e, md_use_d, loaduse_d, exc_req_m, eret_m;
    logic pc_en, ifid_en, idex_clr, exmem_clr, memwb_clr, md_busy, md_done;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stat_stall_cyc, stat_md_stall_cyc, stat_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of occupancy still to go, plus event tallies
    int          m_rem = 0;
    longint      m_stall = 0, m_md_stall = 0, m_flush = 0;

    logic [6:0] got;
    logic [6:0] exp_v;
    assign got = {pc_en, ifid_en, idex_clr, exmem_clr, memwb_clr, md_busy, md_done};

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .md_use_d    (md_use_d),
        .loaduse_d   (loaduse_d),
        .exc_req_m   (exc_req_m),
        .eret_m      (eret_m),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_clr    (idex_clr),
        .exmem_clr   (exmem_clr),
        .memwb_clr   (memwb_clr),
        .md_busy     (md_busy),
        .md_done     (md_done)
`ifdef PIPE_HAZARD_STATS_EN
        ,
        .stat_stall_cyc    (stat_stall_cyc),
        .stat_md_stall_cyc (stat_md_stall_cyc),
        .stat_flush_cnt    (stat_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_eval();
        logic busy, done, start_ok, flush, stall;
        busy     = (m_rem > 0);
        done     = (m_rem == 1);
        start_ok = md_start_e && !exc_req_m && !eret_m;
        flush    = exc_req_m || eret_m;
        stall    = !flush && (loaduse_d || (md_use_d && (busy || start_ok)));
        if (flush)      return {5'b11110, busy, done};
        else if (stall) return {5'b00100, busy, done};
        else            return {5'b11000, busy, done};
    endfunction

    task automatic m_clear();
        m_rem = 0; m_stall = 0; m_md_stall = 0; m_flush = 0;
    endtask

    task automatic tick();
        logic busy, start_ok, flush;
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            busy     = (m_rem > 0);
            start_ok = md_start_e && !exc_req_m && !eret_m;
            flush    = exc_req_m || eret_m;
            if (flush) m_flush++;
            if (!flush && (loaduse_d || (md_use_d && (busy || start_ok)))) m_stall++;
            if (!flush && md_use_d && (busy || start_ok)) m_md_stall++;
            if (busy)          m_rem = m_rem - 1;
            else if (start_ok) m_rem = md_is_div_e ? 10 : 5;
        end
        #1;
    endtask

    task automatic idle_inputs();
        md_start_e = 0; md_is_div_e = 0; md_use_d = 0;
        loaduse_d = 0; exc_req_m = 0; eret_m = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #2 reset = 1;
        m_clear();
        #1;
        checks++;
        if (got !== 7'b1100000) begin
            errors++; $display("FAIL reset_async got=%b exp=%b", got, 7'b1100000);
        end
        repeat (3) tick();
        checks++;
        if (got !== 7'b1100000) begin
            errors++; $display("FAIL reset_hold got=%b exp=%b", got, 7'b1100000);
        end
        @(negedge clk) reset = 0;
        tick();
        checks++;
        if (got !== 7'b1100000) begin
            errors++; $display("FAIL reset_release got=%b exp=%b", got, 7'b1100000);
        end
    endtask

    task automatic test_mult();
        md_start_e = 1; md_is_div_e = 0; md_use_d = 1;
        #1;
        checks++;
        if ({pc_en, md_busy} !== 2'b00) begin
            errors++; $display("FAIL mult_c0 pc_en,busy got=%b exp=00", {pc_en, md_busy});
        end
        tick();
        md_start_e = 0;
        for (int c = 1; c <= 6; c++) begin
            logic [2:0] e;
            e = (c <= 5) ? {1'b1, (c == 5), 1'b0} : 3'b001;
            #1;
            checks++;
            if ({md_busy, md_done, pc_en} !== e) begin
                errors++; $display("FAIL mult_c%0d busy,done,pc_en got=%b exp=%b", c, {md_busy, md_done, pc_en}, e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_div();
        int n_busy = 0, n_stall = 0;
        md_start_e = 1; md_is_div_e = 1; md_use_d = 0;
        #1;
        if (!pc_en) n_stall++;
        tick();
        idle_inputs();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (md_busy) n_busy++;
            if (!pc_en) n_stall++;
            tick();
        end
        checks++;
        if (n_busy != 10) begin
            errors++; $display("FAIL div_busy_len got=%0d exp=10", n_busy);
        end
        checks++;
        if (n_stall != 0) begin
            errors++; $display("FAIL div_no_stall got=%0d exp=0", n_stall);
        end
    endtask

    task automatic test_loaduse();
        loaduse_d = 1;
        #1;
        checks++;
        if ({pc_en, ifid_en, idex_clr, exmem_clr} !== 4'b0010) begin
            errors++; $display("FAIL loaduse_stall got=%b exp=0010", {pc_en, ifid_en, idex_clr, exmem_clr});
        end
        tick();
        loaduse_d = 0;
        #1;
        checks++;
        if ({pc_en, ifid_en, idex_clr, exmem_clr} !== 4'b1100) begin
            errors++; $display("FAIL loaduse_release got=%b exp=1100", {pc_en, ifid_en, idex_clr, exmem_clr});
        end
    endtask

    task automatic test_flush();
        exc_req_m = 1; loaduse_d = 1; md_start_e = 1; md_use_d = 1;
        #1;
        checks++;
        if ({pc_en, ifid_en, idex_clr, exmem_clr, memwb_clr} !== 5'b11110) begin
            errors++; $display("FAIL flush_prio got=%b exp=11110", {pc_en, ifid_en, idex_clr, exmem_clr, memwb_clr});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL flush_no_start busy got=%b exp=0", md_busy);
        end
        md_start_e = 1;
        tick();
        md_start_e = 0;
        for (int c = 1; c <= 6; c++) begin
            logic [1:0] e;
            eret_m   = (c == 2);
            md_use_d = (c == 2);
            e = {(c <= 5), (c == 5)};
            #1;
            if (c == 2) begin
                checks++;
                if ({pc_en, ifid_en, idex_clr, exmem_clr, memwb_clr} !== 5'b11110) begin
                    errors++; $display("FAIL eret_in_busy got=%b exp=11110", {pc_en, ifid_en, idex_clr, exmem_clr, memwb_clr});
                end
            end
            checks++;
            if ({md_busy, md_done} !== e) begin
                errors++; $display("FAIL flush_md_c%0d busy,done got=%b exp=%b", c, {md_busy, md_done}, e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_illegal_start();
        md_start_e = 1;
        tick();
        md_start_e = 0;
        for (int c = 1; c <= 6; c++) begin
            logic [1:0] e;
            md_start_e  = (c == 2);
            md_is_div_e = (c == 2);
            e = {(c <= 5), (c == 5)};
            #1;
            checks++;
            if ({md_busy, md_done} !== e) begin
                errors++; $display("FAIL illegal_c%0d busy,done got=%b exp=%b", c, {md_busy, md_done}, e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        md_start_e = 1; md_is_div_e = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        #2 reset = 1;
        m_clear();
        #1;
        checks++;
        if ({md_busy, md_done} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_busy got=%b exp=00", {md_busy, md_done});
        end
        @(negedge clk) reset = 0;
        tick();
        checks++;
        if (got !== 7'b1100000) begin
            errors++; $display("FAIL reset_mid_release got=%b exp=1100000", got);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            md_start_e  = (m_rem == 0) && ($urandom_range(0, 3) == 0);
            md_is_div_e = $urandom_range(0, 1);
            md_use_d    = ($urandom_range(0, 2) == 0);
            loaduse_d   = ($urandom_range(0, 4) == 0);
            exc_req_m   = ($urandom_range(0, 11) == 0);
            eret_m      = ($urandom_range(0, 15) == 0);
            #1;
            exp_v = model_eval();
            checks++;
            if (got !== exp_v) begin
                errors++;
                if (bad < 10) $display("FAIL random_n%0d got=%b exp=%b", n, got, exp_v);
                bad++;
            end
            tick();
        end
        idle_inputs();
`ifdef PIPE_HAZARD_STATS_EN
        #1;
        checks++;
        if (stat_stall_cyc !== 32'(m_stall)) begin
            errors++; $display("FAIL stat_stall got=%0d exp=%0d", stat_stall_cyc, m_stall);
        end
        checks++;
        if (stat_md_stall_cyc !== 32'(m_md_stall)) begin
            errors++; $display("FAIL stat_md_stall got=%0d exp=%0d", stat_md_stall_cyc, m_md_stall);
        end
        checks++;
        if (stat_flush_cnt !== 32'(m_flush)) begin
            errors++; $display("FAIL stat_flush got=%0d exp=%0d", stat_flush_cnt, m_flush);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_loaduse();
        test_flush();
        test_illegal_start();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
